// File: rtl/mem_pkg.sv
// Shared types and constants for the burst main memory.
// Burst offset width helper tolerates single-beat bursts.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WDATA,
    WAIT,
    RBURST
  } state_t;

  function automatic int off_w(input int n);
    return (n > 1) ? $clog2(n) : 0;
  endfunction

  localparam int BURST_LEN_DFLT = 4;
  localparam int OFF_W = off_w(BURST_LEN_DFLT);

endpackage

// File: rtl/main_memory_burst_if.sv
// Request/beat bus between a client and the burst memory.
// The client drives the master side, the memory the slave side.
interface main_memory_burst_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic              wvalid;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic              ready;
  logic              wready;
  logic              rvalid;
  logic              rlast;
  logic [DATA_W-1:0] rdata;
  logic              done;

  modport master (
    output req, we, addr,
    output wvalid, wdata, wstrb,
    input  ready, wready,
    input  rvalid, rlast, rdata,
    input  done
  );

  modport slave (
    input  req, we, addr,
    input  wvalid, wdata, wstrb,
    output ready, wready,
    output rvalid, rlast, rdata,
    output done
  );

endinterface

// File: rtl/mem_array.sv
// Word storage: one registered read port and one
// byte-strobed write port.
module mem_array #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic [ADDR_W-1:0]   raddr,
  output logic [DATA_W-1:0]   rdata
);

  localparam int SW = DATA_W / 8;

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] wkey;
  logic [DATA_W-1:0] rkey;

  // Words are kept XORed with their own index, so a
  // zero-filled array reads back as mem[i] = i.
  assign wkey = DATA_W'(waddr);
  assign rkey = DATA_W'(raddr);

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < SW; i++) begin
        if (wstrb[i]) begin
          mem[waddr][i*8 +: 8] <=
            wdata[i*8 +: 8] ^ wkey[i*8 +: 8];
        end
      end
    end
    rdata <= mem[raddr] ^ rkey;
  end

endmodule

// File: rtl/main_memory_burst.sv
// Burst main memory: critical-word-first wrapping bursts
// behind a fixed access latency, one transaction at a time.
module main_memory_burst
  import mem_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int LATENCY   = 8,
  parameter int BURST_LEN = 4
) (
  input logic clk,
  input logic rst_n,
  main_memory_burst_if.slave bus
);

  localparam int OW = off_w(BURST_LEN);
  localparam int KW = (OW > 0) ? OW : 1;
  localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int SW = DATA_W / 8;

  localparam logic [ADDR_W-1:0] MASK =
    ADDR_W'(BURST_LEN - 1);
  localparam logic [KW-1:0] KLAST =
    KW'(BURST_LEN - 1);
  localparam logic [LW-1:0] LLAST =
    LW'((LATENCY > 0) ? LATENCY - 1 : 0);

  state_t            state;
  state_t            nstate;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [KW-1:0]     k;
  logic [LW-1:0]     cnt;

  logic              arr_we;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] arr_q;
  logic              klast;
  logic              lend;
  logic              rlast_i;

  function automatic logic [ADDR_W-1:0] beat_addr(
    input logic [ADDR_W-1:0] a,
    input logic [KW-1:0]     kk
  );
    return (a & ~MASK) | ((a + ADDR_W'(kk)) & MASK);
  endfunction

  assign klast = (k == KLAST);
  assign lend  = (cnt == LLAST);

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: begin
        if (bus.req) begin
          if (bus.we)            nstate = WDATA;
          else if (LATENCY == 0) nstate = RBURST;
          else                   nstate = WAIT;
        end
      end
      WDATA: begin
        if (bus.wvalid && klast) begin
          nstate = (LATENCY == 0) ? IDLE : WAIT;
        end
      end
      WAIT: begin
        if (lend) nstate = we_q ? IDLE : RBURST;
      end
      RBURST: begin
        if (klast) nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    rlast_i     = (state == RBURST) && klast;
    bus.ready   = (state == IDLE);
    bus.wready  = (state == WDATA);
    bus.rvalid  = (state == RBURST);
    bus.rlast   = rlast_i;
    bus.rdata   = (state == RBURST) ? arr_q : '0;
    bus.done    = rlast_i
                | ((state == WAIT) && lend && we_q)
                | ((LATENCY == 0) && (state == WDATA)
                   && bus.wvalid && klast);
  end

  // The read port runs one beat ahead so each RBURST
  // cycle already has its word registered.
  always_comb begin
    raddr = beat_addr(addr_q, '0);
    unique case (1'b1)
      (state == IDLE):   raddr = bus.addr;
      (state == RBURST): raddr = beat_addr(addr_q, k + 1'b1);
      default:           raddr = beat_addr(addr_q, '0);
    endcase
  end

  assign arr_we = (state == WDATA) && bus.wvalid;
  assign waddr  = beat_addr(addr_q, k);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      we_q   <= 1'b0;
      addr_q <= '0;
      k      <= '0;
      cnt    <= '0;
    end else begin
      state <= nstate;
      unique case (state)
        IDLE: begin
          if (bus.req) begin
            we_q   <= bus.we;
            addr_q <= bus.addr;
            k      <= '0;
            cnt    <= '0;
          end
        end
        WDATA: begin
          if (bus.wvalid) k <= klast ? '0 : k + 1'b1;
        end
        WAIT: begin
          cnt <= lend ? '0 : cnt + 1'b1;
        end
        RBURST: begin
          k <= klast ? '0 : k + 1'b1;
        end
        default: k <= '0;
      endcase
    end
  end

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (waddr),
    .wdata (bus.wdata),
    .wstrb (bus.wstrb[SW-1:0]),
    .raddr (raddr),
    .rdata (arr_q)
  );

endmodule

// File: tb/tb_main_memory_burst.sv
// Bench for main_memory_burst: timeline model plus
// directed transactions on a LATENCY=4 and a LATENCY=0 build.
module tb_main_memory_burst;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int L  = 4;
  localparam int BL = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  main_memory_burst_if #(.ADDR_W(AW), .DATA_W(DW)) b();
  main_memory_burst_if #(.ADDR_W(AW), .DATA_W(DW)) b0();

  main_memory_burst #(
    .ADDR_W(AW), .DATA_W(DW), .LATENCY(L), .BURST_LEN(BL)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(b.slave));

  main_memory_burst #(
    .ADDR_W(AW), .DATA_W(DW), .LATENCY(0), .BURST_LEN(BL)
  ) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));

  int tests = 0;
  int fails = 0;

  logic [31:0] mm [256];
  bit          busy = 1'b0;
  bit          m_we;
  logic [7:0]  m_addr;
  int          ecnt = 0;
  int          t_acc, t_last, nb;

  logic [31:0] wd [4];
  logic [3:0]  ws [4];

  function automatic logic [7:0] beat(input logic [7:0] a,
                                      input int k);
    logic [1:0] o;
    o = a[1:0] + 2'(k);
    return {a[7:2], o};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  initial for (int i = 0; i < 256; i++) mm[i] = 32'(i);

  // Timeline model: edge index of accept / last write beat
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      busy = 1'b0;
    end else begin
      if (!busy) begin
        if (b.req) begin
          busy = 1'b1; t_acc = ecnt + 1; m_we = b.we;
          m_addr = b.addr; nb = 0; t_last = -1;
        end
      end else if (m_we && t_last < 0 && b.wvalid) begin
        for (int j = 0; j < 4; j++)
          if (b.wstrb[j])
            mm[beat(m_addr, nb)][j*8 +: 8] = b.wdata[j*8 +: 8];
        nb++;
        if (nb == BL) t_last = ecnt + 1;
      end
      ecnt++;
      if (busy && !m_we && ecnt >= t_acc + L + BL) busy = 1'b0;
      if (busy && m_we && t_last >= 0 && ecnt >= t_last + L)
        busy = 1'b0;
    end
  end

  initial forever begin
    logic [4:0]  e;
    logic [31:0] erd;
    bit          erv, erl, edn;
    int          k;
    @(negedge clk);
    erv = 0; erl = 0; edn = 0; erd = '0;
    if (busy && !m_we && ecnt >= t_acc + L) begin
      k = ecnt - t_acc - L;
      erv = 1; erd = mm[beat(m_addr, k)];
      erl = (k == BL - 1); edn = erl;
    end
    if (busy && m_we && t_last >= 0 && ecnt == t_last + L - 1)
      edn = 1;
    e = {!busy, busy && m_we && t_last < 0, erv, erl, edn};
    tests++;
    if ({b.ready, b.wready, b.rvalid, b.rlast, b.done} !== e
        || ((erv || !rst_n) && b.rdata !== erd)) begin
      fails++;
      $display("FAIL cycle%0d rdy/wrdy/rv/rl/dn=%b rdata=%h exp %b %h",
               ecnt, {b.ready, b.wready, b.rvalid, b.rlast, b.done},
               b.rdata, e, erd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!b.ready && n < 50) begin tick(); n++; end
    chk("ready_timeout", 32'(b.ready), 1);
  endtask

  task automatic rd_lit(input logic [7:0] a,
                        input logic [31:0] e0, e1, e2, e3,
                        input string nm);
    logic [31:0] ex [4];
    int first = -1, nv = 0, lastc = -1, donec = -1;
    ex = '{e0, e1, e2, e3};
    wait_ready();
    b.req = 1; b.we = 0; b.addr = a;
    tick();
    b.req = 0;
    for (int c = 1; c <= 12; c++) begin
      if (b.rvalid) begin
        if (first < 0) first = c;
        if (nv < 4) chk({nm, "_data"}, b.rdata, ex[nv]);
        nv++;
        if (b.rlast) lastc = c;
      end
      if (b.done) donec = c;
      tick();
    end
    chk({nm, "_first"}, 32'(first), L + 1);
    chk({nm, "_beats"}, 32'(nv), 4);
    chk({nm, "_rlast"}, 32'(lastc), L + 4);
    chk({nm, "_done"}, 32'(donec), L + 4);
  endtask

  task automatic wr(input logic [7:0] a, input int gap,
                    input bit junk, output int donec);
    int t;
    wait_ready();
    b.req = 1; b.we = 1; b.addr = a;
    tick();
    b.req = 0; b.we = 0; t = 1;
    for (int k = 0; k < 4; k++) begin
      b.wvalid = 1; b.wdata = wd[k]; b.wstrb = ws[k];
      chk("wready_beat", 32'(b.wready), 1);
      tick(); t++;
      if (k == 1) begin
        for (int g = 0; g < gap; g++) begin
          b.wvalid = 0; b.wdata = '1; b.wstrb = '1;
          chk("wready_stall", 32'(b.wready), 1);
          tick(); t++;
        end
      end
    end
    b.wvalid = junk; b.wdata = 32'hDEADBEEF; b.wstrb = '1;
    donec = -1;
    for (int i = 0; i < 20 && donec < 0; i++) begin
      if (b.done) donec = t;
      tick(); t++;
    end
    b.wvalid = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int dc, nd, nrv, nacc;
    b.req = 0; b.we = 0; b.addr = '0;
    b.wvalid = 0; b.wdata = '0; b.wstrb = '0;
    b0.req = 0; b0.we = 0; b0.addr = '0;
    b0.wvalid = 0; b0.wdata = '0; b0.wstrb = '0;
    tick();
    chk("rst_ready", 32'(b.ready), 1);
    chk("rst_wready", 32'(b.wready), 0);
    chk("rst_rvalid", 32'(b.rvalid), 0);
    chk("rst_rlast", 32'(b.rlast), 0);
    chk("rst_done", 32'(b.done), 0);
    chk("rst_rdata", b.rdata, 0);
    repeat (2) tick();
    rst_n = 1;
    tick();

    rd_lit(8'h06, 32'h6, 32'h7, 32'h4, 32'h5, "rd06");

    wd = '{32'hAABBCCDD, 32'h11111111, 32'h11111111, 32'h11111111};
    ws = '{4'b0011, 4'b1111, 4'b1111, 4'b1111};
    wr(8'h10, 0, 1'b0, dc);
    chk("wr10_done_t", 32'(dc), 8);
    rd_lit(8'h10, 32'h0000CCDD, 32'h11111111, 32'h11111111,
           32'h11111111, "rd10");

    wd = '{32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F00};
    ws = '{4'hF, 4'hF, 4'hF, 4'hF};
    wr(8'h22, 3, 1'b1, dc);
    chk("wr22_gap_done_t", 32'(dc), 11);
    rd_lit(8'h20, 32'h090A0B0C, 32'h0D0E0F00, 32'h01020304,
           32'h05060708, "rd20");
    rd_lit(8'h24, 32'h24, 32'h25, 32'h26, 32'h27, "rd24");

    wait_ready();
    b.req = 1; b.we = 0; b.addr = 8'h30;
    tick();
    nd = 0; nrv = 0; nacc = 0;
    for (int c = 1; c <= 17; c++) begin
      if (b.done) nd++;
      if (b.rvalid) nrv++;
      if (b.ready) nacc++;
      if (c == 17) b.req = 0;
      tick();
    end
    chk("hold_dones", 32'(nd), 2);
    chk("hold_rvalids", 32'(nrv), 8);
    chk("hold_accepts", 32'(nacc), 1);

    wait_ready();
    b.req = 1; b.we = 0; b.addr = 8'h08;
    tick();
    b.req = 0;
    repeat (6) tick();
    chk("rb_beat2", b.rdata, 32'h0A);
    rst_n = 0;
    #1;
    chk("rb_rst_rvalid", 32'(b.rvalid), 0);
    chk("rb_rst_rlast", 32'(b.rlast), 0);
    chk("rb_rst_done", 32'(b.done), 0);
    chk("rb_rst_ready", 32'(b.ready), 1);
    tick();
    rst_n = 1;
    tick();
    rd_lit(8'h40, 32'h40, 32'h41, 32'h42, 32'h43, "rd40");

    wait_ready();
    b.req = 1; b.we = 1; b.addr = 8'h50;
    tick();
    b.req = 0; b.we = 0;
    b.wvalid = 1; b.wstrb = '1; b.wdata = 32'hA0A0A0A0;
    tick();
    b.wdata = 32'hB1B1B1B1;
    tick();
    b.wvalid = 0;
    rst_n = 0;
    #1;
    chk("wr_rst_wready", 32'(b.wready), 0);
    chk("wr_rst_done", 32'(b.done), 0);
    tick();
    rst_n = 1;
    tick();
    rd_lit(8'h50, 32'hA0A0A0A0, 32'hB1B1B1B1, 32'h52, 32'h53,
           "rd50");

    b0.req = 1; b0.we = 0; b0.addr = 8'h00;
    tick();
    b0.req = 0;
    for (int c = 1; c <= 6; c++) begin
      chk("l0_rvalid", 32'(b0.rvalid), 32'(c <= 4));
      if (c <= 4) chk("l0_rdata", b0.rdata, 32'(c - 1));
      chk("l0_done", 32'(b0.done), 32'(c == 4));
      chk("l0_ready", 32'(b0.ready), 32'(c >= 5));
      tick();
    end
    b0.req = 1; b0.we = 1; b0.addr = 8'h04;
    tick();
    b0.req = 0; b0.we = 0;
    for (int k = 0; k < 4; k++) begin
      b0.wvalid = 1; b0.wstrb = '1; b0.wdata = 32'hC0 + 32'(k);
      #1;
      chk("l0_wr_done", 32'(b0.done), 32'(k == 3));
      tick();
    end
    b0.wvalid = 0;
    chk("l0_wr_idle", 32'(b0.ready), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
